// File: rtl/iir_pkg.sv
// Shared IIR filter constants: default word widths, coefficients
// and the round/saturate constants used by the decimating quantizer.
package iir_pkg;

  localparam int IIR_WORD_IN  = 18;
  localparam int IIR_WORD_OUT = 8;
  localparam int IIR_DEC_LOG2 = 2;

  localparam logic signed [17:0] IIR_B0 = 18'sd8192;
  localparam logic signed [17:0] IIR_B1 = 18'sd8192;
  localparam logic signed [17:0] IIR_A1 = -18'sd16384;

  function automatic int iir_shift(int win, int wout, int dlog);
    return dlog + win - wout;
  endfunction

  function automatic int iir_sat_max(int wout);
    return (1 <<< (wout - 1)) - 1;
  endfunction

  function automatic int iir_sat_min(int wout);
    return -(1 <<< (wout - 1));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (PW+1)'(depth);
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/iir_decim_quant.sv
// Decimate-by-D accumulator with round-half-up, saturation to
// WORD_OUT bits and a small output FIFO with sticky status flags.
module iir_decim_quant
  import iir_pkg::*;
#(
  parameter int WORD_IN    = IIR_WORD_IN,
  parameter int WORD_OUT   = IIR_WORD_OUT,
  parameter int DEC_LOG2   = IIR_DEC_LOG2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_IN-1:0]  din,
  input  logic                din_stb,
  output logic [WORD_OUT-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                sat_flag,
  output logic                ovf_flag,
  input  logic                clr_flags
);

  localparam int AW = WORD_IN + DEC_LOG2;
  localparam int S  = iir_shift(WORD_IN, WORD_OUT, DEC_LOG2);

  localparam logic signed [AW:0] RND  = (AW+1)'(1) << (S - 1);
  localparam logic signed [AW:0] MAXV = (AW+1)'(iir_sat_max(WORD_OUT));
  localparam logic signed [AW:0] MINV = (AW+1)'(iir_sat_min(WORD_OUT));

  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   sum;
  logic signed [AW:0]     rnd;
  logic signed [AW:0]     shf;
  logic [DEC_LOG2-1:0]    phase;
  logic                   last;
  logic                   clip_hi;
  logic                   clip_lo;
  logic [WORD_OUT-1:0]    q;
  logic [WORD_OUT-1:0]    head;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;

  assign last = &phase;
  assign sum  = acc + signed'({{DEC_LOG2{din[WORD_IN-1]}}, din});
  assign rnd  = signed'({sum[AW-1], sum}) + RND;
  assign shf  = rnd >>> S;

  assign clip_hi = shf > MAXV;
  assign clip_lo = shf < MINV;

  always_comb begin
    q = shf[WORD_OUT-1:0];
    unique case (1'b1)
      clip_hi: q = MAXV[WORD_OUT-1:0];
      clip_lo: q = MINV[WORD_OUT-1:0];
      default: q = shf[WORD_OUT-1:0];
    endcase
  end

  assign push       = din_stb & last;
  assign dout_valid = ~empty;
  assign pop        = dout_valid & dout_ready;
  assign dout       = dout_valid ? head : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      phase <= '0;
    end else if (din_stb) begin
      acc   <= last ? '0 : sum;
      phase <= phase + 1'b1;
    end
  end

  // set beats clear when both happen in one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (push & (clip_hi | clip_lo)) sat_flag <= 1'b1;
      else if (clr_flags)             sat_flag <= 1'b0;
      if (push & full & ~pop)         ovf_flag <= 1'b1;
      else if (clr_flags)             ovf_flag <= 1'b0;
    end
  end

  sync_fifo #(
    .width(WORD_OUT),
    .depth(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(q),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_iir_decim_quant.sv
// Directed-vector bench for iir_decim_quant at default parameters
// (D=4, S=12); expected values are hand-computed.
module tb_iir_decim_quant;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] din = '0;
  logic        din_stb = 1'b0;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        sat_flag;
  logic        ovf_flag;
  logic        clr_flags = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iir_decim_quant dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_stb   (din_stb),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .sat_flag  (sat_flag),
    .ovf_flag  (ovf_flag),
    .clr_flags (clr_flags)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic feed(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      din     = v[17:0];
      din_stb = 1'b1;
      @(negedge clk);
    end
    din_stb = 1'b0;
  endtask

  task automatic pop1;
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic clr;
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_sat", 32'(sat_flag), 32'h0);
    check("rst_ovf", 32'(ovf_flag), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    feed(1024, 3);
    din = 18'd1024;
    din_stb = 1'b1;
    check("lat_pre", 32'(dout_valid), 32'h0);
    @(negedge clk);
    din_stb = 1'b0;
    check("basic_valid", 32'(dout_valid), 32'h1);
    check("basic_dout", 32'(dout), 32'h1);
    check("basic_sat", 32'(sat_flag), 32'h0);
    pop1();
    check("basic_empty", 32'(dout_valid), 32'h0);

    feed(512, 4);
    feed(511, 4);
    check("rnd_up", 32'(dout), 32'h1);
    pop1();
    check("rnd_down", 32'(dout), 32'h0);
    check("rnd_valid", 32'(dout_valid), 32'h1);
    pop1();
    check("rnd_empty", 32'(dout_valid), 32'h0);

    feed(131071, 4);
    check("sat_max", 32'(dout), 32'h7f);
    check("sat_set", 32'(sat_flag), 32'h1);
    pop1();
    clr();
    check("sat_clr", 32'(sat_flag), 32'h0);
    feed(-131072, 4);
    check("sat_min", 32'(dout), 32'h80);
    check("sat_min_noclip", 32'(sat_flag), 32'h0);
    pop1();

    feed(131071, 3);
    din = 18'h1ffff;
    din_stb = 1'b1;
    clr_flags = 1'b1;
    @(negedge clk);
    din_stb = 1'b0;
    clr_flags = 1'b0;
    check("set_wins", 32'(sat_flag), 32'h1);
    pop1();
    clr();

    for (int k = 1; k <= 5; k++) begin
      feed(1024 * k, 4);
      check("ovf_hold", 32'(dout), 32'h1);
    end
    check("ovf_set", 32'(ovf_flag), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      check("ovf_drain", 32'(dout), 32'(k));
      pop1();
    end
    check("ovf_empty", 32'(dout_valid), 32'h0);
    clr();
    check("ovf_clr", 32'(ovf_flag), 32'h0);

    for (int k = 6; k <= 9; k++) feed(1024 * k, 4);
    check("full_cnt", 32'(dut.u_fifo.count), 32'd4);
    feed(10240, 3);
    din = 18'd10240;
    din_stb = 1'b1;
    dout_ready = 1'b1;
    @(negedge clk);
    din_stb = 1'b0;
    dout_ready = 1'b0;
    check("pp_cnt", 32'(dut.u_fifo.count), 32'd4);
    check("pp_ovf", 32'(ovf_flag), 32'h0);
    for (int k = 7; k <= 10; k++) begin
      check("pp_drain", 32'(dout), 32'(k));
      pop1();
    end
    check("pp_empty", 32'(dout_valid), 32'h0);

    feed(5000, 2);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(dout_valid), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    feed(1024, 4);
    check("post_rst_dout", 32'(dout), 32'h1);
    pop1();
    check("post_rst_one", 32'(dout_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
